// File: rtl/bus_interface_n_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_interface_n_if
// Description : Signal bundle between the CPU native memory bus, the ROM and
//               RAM ports and the NUM_PERIPH valid/ready peripheral slots.
//               slave  : view taken by the decoder (bus_interface_n); it
//                        receives CPU requests and drives the target ports.
//               master : view taken by the surrounding system (CPU and
//                        targets).
//   mem_*    : CPU request/response (valid, instr, addr, wdata, wstrb /
//              ready, rdata)
//   rom_*    : ROM enable, word address, read data
//   ram_*    : RAM enable, byte write enables, word address, wdata, rdata
//   periph_* : one-hot slot valid, slot ready, word address, wdata, wstrb,
//              packed per-slot read data (slot s at [32s+31:32s])
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_interface_n_if #(
    parameter int ROM_AW     = 15,
    parameter int RAM_AW     = 14,
    parameter int PERIPH_AW  = 3,
    parameter int NUM_PERIPH = 2
);
    logic                       mem_valid;
    logic                       mem_instr;
    logic [31:0]                mem_addr;
    logic [31:0]                mem_wdata;
    logic [3:0]                 mem_wstrb;
    logic                       mem_ready;
    logic [31:0]                mem_rdata;

    logic                       rom_en;
    logic [ROM_AW-1:0]          rom_addr;
    logic [31:0]                rom_rdata;

    logic                       ram_en;
    logic [3:0]                 ram_wea;
    logic [RAM_AW-1:0]          ram_addr;
    logic [31:0]                ram_wdata;
    logic [31:0]                ram_rdata;

    logic [NUM_PERIPH-1:0]      periph_valid;
    logic [NUM_PERIPH-1:0]      periph_ready;
    logic [PERIPH_AW-1:0]       periph_addr;
    logic [31:0]                periph_wdata;
    logic [3:0]                 periph_wstrb;
    logic [32*NUM_PERIPH-1:0]   periph_rdata;

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output rom_en, rom_addr,
        input  rom_rdata,
        output ram_en, ram_wea, ram_addr, ram_wdata,
        input  ram_rdata,
        output periph_valid, periph_addr, periph_wdata, periph_wstrb,
        input  periph_ready, periph_rdata
    );

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  rom_en, rom_addr,
        output rom_rdata,
        input  ram_en, ram_wea, ram_addr, ram_wdata,
        output ram_rdata,
        input  periph_valid, periph_addr, periph_wdata, periph_wstrb,
        output periph_ready, periph_rdata
    );
endinterface
`default_nettype wire

// File: rtl/bus_interface_n.sv
`default_nettype none
// ============================================================================
// Module      : bus_interface_n
// Description : Decodes the picorv32 native memory bus onto a ROM port, a RAM
//               port and NUM_PERIPH valid/ready peripheral slots, with
//               configurable ROM/RAM read latency, peripheral timeout, ROM
//               write protection and sticky first-error capture.
//   clk, reset : clock, synchronous active-high reset
//   bus        : bus_interface_n_if.slave (CPU, ROM, RAM, peripheral slots)
//   err_clr    : clears the sticky error
//   bus_err    : sticky error flag
//   err_cause  : 01 unmapped, 10 ROM write, 11 peripheral timeout
//   err_addr   : address of the first error since the last clear
// Revision    : 1.0 - initial release
// ============================================================================
module bus_interface_n #(
    parameter int          ROM_AW      = 15,
    parameter int          RAM_AW      = 14,
    parameter int          PERIPH_AW   = 3,
    parameter int          NUM_PERIPH  = 2,
    parameter logic [31:0] ROM_BASE    = 32'h0000_0000,
    parameter logic [31:0] RAM_BASE    = 32'h0010_0000,
    parameter logic [31:0] PERIPH_BASE = 32'h0200_0000,
    parameter int          ROM_LAT     = 2,
    parameter int          RAM_LAT     = 1,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  wire logic        clk,
    input  wire logic        reset,
    bus_interface_n_if.slave bus,
    input  wire logic        err_clr,
    output logic             bus_err,
    output logic [1:0]       err_cause,
    output logic [31:0]      err_addr
);
    localparam int c_sel_w   = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
    localparam int c_lat_max = (ROM_LAT > RAM_LAT) ? ROM_LAT : RAM_LAT;
    localparam int c_lw      = (c_lat_max < 2) ? 1 : $clog2(c_lat_max + 1);
    localparam int c_tw      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int c_plo     = PERIPH_AW + 2 + c_sel_w;

    localparam logic [c_lw-1:0] c_rom_cnt = c_lw'(ROM_LAT - 1);
    localparam logic [c_lw-1:0] c_ram_cnt = c_lw'(RAM_LAT - 1);
    localparam logic [c_tw-1:0] c_timeout = c_tw'(TIMEOUT);
    localparam logic [31:0]     c_rom_base = ROM_BASE;
    localparam logic [31:0]     c_ram_base = RAM_BASE;
    localparam logic [31:0]     c_per_base = PERIPH_BASE;

    // Where mem_rdata comes from in the response cycle
    localparam logic [1:0] c_src_reg = 2'd0;
    localparam logic [1:0] c_src_rom = 2'd1;
    localparam logic [1:0] c_src_ram = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_MEM_WAIT    = 2'd1,
        S_PERIPH_WAIT = 2'd2,
        S_RESP        = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_lw-1:0]        r_cnt;
    logic [c_tw-1:0]        r_tcnt;
    logic [1:0]             r_src;
    logic [31:0]            r_rdata;
    logic [NUM_PERIPH-1:0]  r_per_valid;
    logic [PERIPH_AW-1:0]   r_per_addr;
    logic [31:0]            r_per_wdata;
    logic [3:0]             r_per_wstrb;
    logic                   r_per_wr;
    logic [31:0]            r_req_addr;
    logic                   r_bus_err;
    logic [1:0]             r_err_cause;
    logic [31:0]            r_err_addr;

    logic w_accept, w_is_wr, w_hit_rom, w_hit_ram, w_hit_per, w_slot_ok;
    logic w_rom_rd, w_ram_go, w_per_go, w_bad, w_slot_ready, w_expire, w_err_evt;
    logic [c_sel_w-1:0]    w_slot;
    logic [NUM_PERIPH-1:0] w_onehot;
    logic [31:0]           w_sel_rdata, w_rdata;
    logic [1:0]            w_err_cause;
    logic [31:0]           w_err_addr;

    // Instruction flag and byte offset do not affect decoding
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, bus.mem_instr, bus.mem_addr[1:0]};

    // Address decode; regions are aligned so a compare of upper bits suffices
    assign w_accept  = (r_state == S_IDLE) && bus.mem_valid && !reset;
    assign w_is_wr   = |bus.mem_wstrb;
    assign w_hit_rom = bus.mem_addr[31:ROM_AW+2] == c_rom_base[31:ROM_AW+2];
    assign w_hit_ram = bus.mem_addr[31:RAM_AW+2] == c_ram_base[31:RAM_AW+2];
    assign w_hit_per = bus.mem_addr[31:c_plo] == c_per_base[31:c_plo];
    assign w_slot    = bus.mem_addr[PERIPH_AW+2 +: c_sel_w];
    assign w_slot_ok = 32'(w_slot) < 32'(NUM_PERIPH);

    assign w_rom_rd = w_accept && w_hit_rom && !w_is_wr;
    assign w_ram_go = w_accept && !w_hit_rom && w_hit_ram;
    assign w_per_go = w_accept && !w_hit_rom && !w_hit_ram && w_hit_per && w_slot_ok;
    // ROM writes and anything unmapped complete immediately as errors
    assign w_bad    = w_accept && !w_rom_rd && !w_ram_go && !w_per_go;

    always_comb begin
        w_onehot    = '0;
        w_sel_rdata = '0;
        for (int s = 0; s < NUM_PERIPH; s++) begin
            if (w_slot == c_sel_w'(s)) w_onehot[s] = 1'b1;
            if (r_per_valid[s]) w_sel_rdata = bus.periph_rdata[32*s +: 32];
        end
    end

    // Only the addressed slot's ready is seen, since only its valid is set
    assign w_slot_ready = |(r_per_valid & bus.periph_ready);
    // A ready in the expiry cycle wins over the timeout
    assign w_expire     = (TIMEOUT != 0) && (r_state == S_PERIPH_WAIT) &&
                          (r_tcnt == c_timeout) && !w_slot_ready;

    assign w_err_evt   = w_bad || w_expire;
    assign w_err_cause = w_bad ? (w_hit_rom ? 2'b10 : 2'b01) : 2'b11;
    assign w_err_addr  = w_bad ? bus.mem_addr : r_req_addr;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_rom_rd)
                        w_state_nxt = (ROM_LAT > 1) ? S_MEM_WAIT : S_RESP;
                    else if (w_ram_go)
                        w_state_nxt = (!w_is_wr && RAM_LAT > 1) ? S_MEM_WAIT : S_RESP;
                    else if (w_per_go)
                        w_state_nxt = S_PERIPH_WAIT;
                    else
                        w_state_nxt = S_RESP;
                end
            end
            S_MEM_WAIT:    if (r_cnt <= c_lw'(1)) w_state_nxt = S_RESP;
            S_PERIPH_WAIT: if (w_slot_ready || w_expire) w_state_nxt = S_RESP;
            S_RESP:        w_state_nxt = S_IDLE;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- Datapath and error capture ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_src       <= c_src_reg;
            r_rdata     <= '0;
            r_per_valid <= '0;
            r_per_addr  <= '0;
            r_per_wdata <= '0;
            r_per_wstrb <= '0;
            r_per_wr    <= 1'b0;
            r_req_addr  <= '0;
            r_bus_err   <= 1'b0;
            r_err_cause <= 2'b00;
            r_err_addr  <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= w_rom_rd ? c_rom_cnt : c_ram_cnt;
                r_src   <= w_rom_rd ? c_src_rom :
                           (w_ram_go && !w_is_wr) ? c_src_ram : c_src_reg;
                r_rdata <= w_bad ? ERR_DATA : 32'h0;
                if (w_per_go) begin
                    r_per_valid <= w_onehot;
                    r_per_addr  <= bus.mem_addr[PERIPH_AW+1:2];
                    r_per_wdata <= bus.mem_wdata;
                    r_per_wstrb <= bus.mem_wstrb;
                    r_per_wr    <= w_is_wr;
                    r_req_addr  <= bus.mem_addr;
                    r_tcnt      <= c_tw'(1);
                end
            end
            if (r_state == S_MEM_WAIT) r_cnt <= r_cnt - c_lw'(1);
            if (r_state == S_PERIPH_WAIT) begin
                r_tcnt <= r_tcnt + c_tw'(1);
                if (w_slot_ready || w_expire) begin
                    r_per_valid <= '0;
                    r_per_addr  <= '0;
                    r_per_wdata <= '0;
                    r_per_wstrb <= '0;
                    r_rdata     <= w_expire ? ERR_DATA :
                                   (r_per_wr ? 32'h0 : w_sel_rdata);
                end
            end
            // First error sticks; a new error beats a simultaneous clear
            if (w_err_evt && (!r_bus_err || err_clr)) begin
                r_bus_err   <= 1'b1;
                r_err_cause <= w_err_cause;
                r_err_addr  <= w_err_addr;
            end else if (err_clr) begin
                r_bus_err   <= 1'b0;
                r_err_cause <= 2'b00;
                r_err_addr  <= '0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (r_state == S_RESP) begin
            case (r_src)
                c_src_rom: w_rdata = bus.rom_rdata;
                c_src_ram: w_rdata = bus.ram_rdata;
                default:   w_rdata = r_rdata;
            endcase
        end
    end

    // ---------------- Outputs ----------------
    assign bus.mem_ready    = (r_state == S_RESP);
    assign bus.mem_rdata    = w_rdata;
    assign bus.rom_en       = w_rom_rd;
    assign bus.rom_addr     = w_rom_rd ? bus.mem_addr[ROM_AW+1:2] : '0;
    assign bus.ram_en       = w_ram_go;
    assign bus.ram_wea      = w_ram_go ? bus.mem_wstrb : 4'h0;
    assign bus.ram_addr     = w_ram_go ? bus.mem_addr[RAM_AW+1:2] : '0;
    assign bus.ram_wdata    = w_ram_go ? bus.mem_wdata : 32'h0;
    assign bus.periph_valid = r_per_valid;
    assign bus.periph_addr  = r_per_addr;
    assign bus.periph_wdata = r_per_wdata;
    assign bus.periph_wstrb = r_per_wstrb;
    assign bus_err          = r_bus_err;
    assign err_cause        = r_err_cause;
    assign err_addr         = r_err_addr;
endmodule
`default_nettype wire

// File: tb/tb_bus_interface_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_interface_n
// Description : Self-checking bench for bus_interface_n. Directed scenarios
//               followed by random transactions, checked against an
//               address-range reference model of the memory map, latencies
//               and sticky error register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_interface_n;
    localparam int          ROM_AW     = 15;
    localparam int          RAM_AW     = 14;
    localparam int          PERIPH_AW  = 3;
    localparam int          NUM_PERIPH = 3;
    localparam int          ROM_LAT    = 2;
    localparam int          RAM_LAT    = 1;
    localparam int          TIMEOUT    = 8;
    localparam logic [31:0] ERR        = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        err_clr = 1'b0;
    logic        bus_err;
    logic [1:0]  err_cause;
    logic [31:0] err_addr;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] ref_mem [int];
    logic        ref_err = 1'b0;
    logic [1:0]  ref_cause = 2'b00;
    logic [31:0] ref_eaddr = 32'h0;

    // Emulated RAM contents (written only by the DUT's RAM port)
    logic [31:0] emu_mem [int];

    bus_interface_n_if #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .PERIPH_AW(PERIPH_AW),
                         .NUM_PERIPH(NUM_PERIPH)) bus ();

    bus_interface_n #(
        .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .PERIPH_AW(PERIPH_AW),
        .NUM_PERIPH(NUM_PERIPH), .ROM_BASE(32'h0000_0000),
        .RAM_BASE(32'h0010_0000), .PERIPH_BASE(32'h0200_0000),
        .ROM_LAT(ROM_LAT), .RAM_LAT(RAM_LAT), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .err_clr(err_clr),
        .bus_err(bus_err), .err_cause(err_cause), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_func(input logic [ROM_AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // ROM target: one-cycle synchronous read, held until the next enable
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_rdata <= rom_func(bus.rom_addr);
    end

    // RAM target: synchronous read-old-data with byte writes
    always @(posedge clk) begin
        logic [31:0] w;
        int          idx;
        if (bus.ram_en) begin
            idx = int'(bus.ram_addr);
            w = emu_mem.exists(idx) ? emu_mem[idx] : 32'h0;
            bus.ram_rdata <= w;
            for (int b = 0; b < 4; b++)
                if (bus.ram_wea[b]) w[8*b +: 8] = bus.ram_wdata[8*b +: 8];
            emu_mem[idx] = w;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    endtask

    // kind: 0 ROM, 1 RAM, 2 peripheral slot, 3 unmapped
    function automatic void decode(input logic [31:0] a, output int kind, output int slot);
        slot = 0;
        if (a < 32'h0002_0000) kind = 0;
        else if (a >= 32'h0010_0000 && a < 32'h0011_0000) kind = 1;
        else if (a >= 32'h0200_0000 && a < 32'h0200_0080) begin
            slot = int'((a - 32'h0200_0000) / 32);
            kind = (slot < NUM_PERIPH) ? 2 : 3;
        end else kind = 3;
    endfunction

    task automatic check_errs(input string tag);
        check({tag, "/bus_err"}, 32'(bus_err), 32'(ref_err));
        check({tag, "/err_cause"}, 32'(err_cause), 32'(ref_cause));
        check({tag, "/err_addr"}, err_addr, ref_eaddr);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/ctl"}, 32'({bus.mem_ready, bus.rom_en, bus.ram_en, bus.ram_wea,
                                  bus.periph_valid, bus.periph_wstrb, bus_err, err_cause}), 32'h0);
        check({tag, "/mem_rdata"}, bus.mem_rdata, 32'h0);
        check({tag, "/addrs"}, 32'({bus.rom_addr, bus.ram_addr}), 32'h0);
        check({tag, "/periph_addr"}, 32'(bus.periph_addr), 32'h0);
        check({tag, "/wdata"}, bus.periph_wdata | bus.ram_wdata, 32'h0);
        check({tag, "/err_addr"}, err_addr, 32'h0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        ref_err = 1'b0; ref_cause = 2'b00; ref_eaddr = 32'h0;
        #1;
        check_errs("clr");
    endtask

    // One CPU transaction; d = cycle after T at which the slot raises ready
    task automatic txn(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                       input int d, input bit clr_t, input string tag);
        int kind, slot, lat, vcnt, wi;
        logic [31:0] want, old;
        logic [31:0] pdata [NUM_PERIPH];
        logic [NUM_PERIPH-1:0] oh, rdy;
        logic [1:0] cause;
        bit err, done;
        decode(a, kind, slot);
        oh = (kind == 2) ? NUM_PERIPH'(1) << slot : '0;
        for (int s = 0; s < NUM_PERIPH; s++) begin
            pdata[s] = $urandom;
            bus.periph_rdata[32*s +: 32] = pdata[s];
        end
        err = 1'b0; cause = 2'b00; lat = 1; want = 32'h0;
        wi = int'(a[31:2]);
        case (kind)
            0: if (ws != 0) begin want = ERR; err = 1'b1; cause = 2'b10; end
               else begin lat = ROM_LAT; want = rom_func(a[ROM_AW+1:2]); end
            1: begin
                old = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
                if (ws != 0) begin
                    for (int b = 0; b < 4; b++) if (ws[b]) old[8*b +: 8] = wd[8*b +: 8];
                    ref_mem[wi] = old;
                end else begin lat = RAM_LAT; want = old; end
            end
            2: if (d <= TIMEOUT) begin lat = d + 1; want = (ws != 0) ? 32'h0 : pdata[slot]; end
               else begin lat = TIMEOUT + 1; want = ERR; err = 1'b1; cause = 2'b11; end
            default: begin want = ERR; err = 1'b1; cause = 2'b01; end
        endcase
        if (clr_t) begin ref_err = 1'b0; ref_cause = 2'b00; ref_eaddr = 32'h0; end
        if (err && !ref_err) begin ref_err = 1'b1; ref_cause = cause; ref_eaddr = a; end

        // Cycle T
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_wstrb = ws; bus.mem_wdata = wd;
        err_clr = clr_t;
        #1;
        check({tag, "/enables_T"}, 32'({bus.rom_en, bus.ram_en, bus.ram_wea, bus.periph_valid}),
              32'({kind == 0 && ws == 0, kind == 1, (kind == 1) ? ws : 4'h0, {NUM_PERIPH{1'b0}}}));
        if (kind == 0 && ws == 0) check({tag, "/rom_addr"}, 32'(bus.rom_addr), a >> 2);
        if (kind == 1) check({tag, "/ram_addr"}, 32'(bus.ram_addr), (a - 32'h0010_0000) >> 2);

        done = 1'b0; vcnt = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            bus.mem_valid = 1'b0; bus.mem_wstrb = 4'h0; err_clr = 1'b0;
            rdy = NUM_PERIPH'($urandom) & ~oh;
            if (cyc == d) rdy = rdy | oh;
            bus.periph_ready = rdy;
            #1;
            if (bus.periph_valid != 0) vcnt++;
            if (kind == 2 && cyc == 1) begin
                check({tag, "/pvalid"}, 32'(bus.periph_valid), 32'(oh));
                check({tag, "/paddr"}, 32'(bus.periph_addr), (a >> 2) & 32'h7);
                check({tag, "/pwr"}, {bus.periph_wdata[27:0], bus.periph_wstrb}, {wd[27:0], ws});
            end
            if (bus.mem_ready) begin
                done = 1'b1;
                check({tag, "/latency"}, 32'(cyc), 32'(lat));
                check({tag, "/rdata"}, bus.mem_rdata, want);
                check_errs(tag);
            end else begin
                check({tag, "/rdata_idle"}, bus.mem_rdata, 32'h0);
            end
        end
        bus.periph_ready = '0;
        check({tag, "/completed"}, 32'(done), 32'h1);
        check({tag, "/valid_cycles"}, 32'(vcnt),
              (kind == 2) ? 32'((d < TIMEOUT) ? d : TIMEOUT) : 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [31:0] a;
        logic [3:0]  ws;
        bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = 32'h0;
        bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'h0; bus.periph_ready = '0;
        bus.periph_rdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // ROM read, RAM write then read back
        txn(32'h0000_0010, 4'h0, 32'h0, 0, 1'b0, "rom_rd");
        txn(32'h0010_0008, 4'b0011, 32'hA1B2_C3D4, 0, 1'b0, "ram_wr");
        txn(32'h0010_0008, 4'h0, 32'h0, 0, 1'b0, "ram_rd");

        // Peripheral success, timeout, and ready exactly at expiry
        txn(32'h0200_0020, 4'h0, 32'h0, 5, 1'b0, "p1_rd");
        txn(32'h0200_0000, 4'h0, 32'h0, 100, 1'b0, "p0_timeout");
        pulse_clr();
        txn(32'h0200_0044, 4'hF, 32'h1357_9BDF, TIMEOUT, 1'b0, "p2_wr_edge");

        // ROM write protection, sticky error, clear, error beating a clear
        txn(32'h0000_0004, 4'hF, 32'hFFFF_FFFF, 0, 1'b0, "rom_wr");
        txn(32'h0800_0000, 4'h0, 32'h0, 0, 1'b0, "unmapped");
        pulse_clr();
        txn(32'h0800_0000, 4'h0, 32'h0, 0, 1'b0, "unmapped2");
        txn(32'h0200_0064, 4'h0, 32'h0, 1, 1'b1, "slot3_clr");
        txn(32'h0000_0004, 4'h0, 32'h0, 0, 1'b0, "rom_rd4");

        // Reset in the middle of a peripheral wait (error still pending)
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h0200_0000; bus.mem_wstrb = 4'h0;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        #1;
        check("rst_mid/pvalid_before", 32'(bus.periph_valid), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("rst_mid");
        ref_err = 1'b0; ref_cause = 2'b00; ref_eaddr = 32'h0;
        txn(32'h0010_0008, 4'h0, 32'h0, 0, 1'b0, "ram_rd_after_rst");

        // Random traffic across the whole map
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: a = 32'($urandom_range(0, 32'h1FFFF)) & 32'hFFFF_FFFC;
                1, 4: a = 32'h0010_0000 + 32'($urandom_range(0, 15)) * 4;
                2: a = 32'h0200_0000 + 32'($urandom_range(0, 31)) * 4;
                default: a = 32'h0400_0000 + 32'($urandom_range(0, 255)) * 4;
            endcase
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            txn(a, ws, $urandom, $urandom_range(1, TIMEOUT + 2),
                $urandom_range(0, 5) == 0, "rand");
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
